// File: rtl/letter_line_ctrl.sv
// Display-line letter store: strobe edge -> ring buffer with backspace, clear sweep and scroll-on-full.
// Events act two edges after sampling, reads return one edge after RD_IDX; no backpressure, events during BUSY are dropped.
module letter_line_ctrl #(
  parameter int         DEPTH = 16,
  parameter int         IW    = 4,
  parameter logic [4:0] BLANK = 5'd31
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          STROBE,
  input  logic [4:0]    LETTER,
  input  logic          BKSP,
  input  logic          CLR,
  input  logic [IW-1:0] RD_IDX,
  output logic [4:0]    RD_LETTER,
  output logic [IW:0]   COUNT,
  output logic          FULL,
  output logic          BUSY,
  output logic          DROP
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [IW:0]   DEPTH_C  = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_C   = IW'(DEPTH - 1);
  localparam logic [IW-1:0] ONE_I    = IW'(1);
  localparam logic [IW:0]   ONE_C    = (IW+1)'(1);
  localparam logic [4:0]    MAX_CODE = 5'd25;

  state_t        state_q, state_d;
  logic [IW-1:0] sweep_q, sweep_d;
  logic [IW-1:0] head_q, head_d;
  logic [IW:0]   count_q, count_d;
  logic          strobe_q, strobe_d;
  logic          ev_q, ev_d;
  logic [4:0]    letter_q, letter_d;
  logic          bksp_q, bksp_d;
  logic          clr_q, clr_d;
  logic          drop_q, drop_d;
  logic          full_q, full_d;
  logic [4:0]    rd_letter_q, rd_letter_d;

  logic [4:0]    mem_q [DEPTH];
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [4:0]    wr_dat;
  logic [IW-1:0] cnt_lo;

  assign cnt_lo = count_q[IW-1:0];

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    head_d   = head_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    wr_addr  = sweep_q;
    wr_dat   = BLANK;
    strobe_d = STROBE;
    ev_d     = STROBE & ~strobe_q;
    letter_d = LETTER;
    bksp_d   = BKSP;
    clr_d    = CLR;

    case (state_q)
      ST_CLEAR: begin
        if (clr_q) begin
          sweep_d = '0;
        end else begin
          wr_en   = 1'b1;
          wr_addr = sweep_q;
          sweep_d = sweep_q + ONE_I;
          if (sweep_q == LAST_C) begin
            state_d = ST_IDLE;
            head_d  = '0;
            count_d = '0;
          end
        end
      end
      default: begin
        if (clr_q) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end else if (bksp_q) begin
          if (count_q != '0) begin
            wr_en   = 1'b1;
            wr_addr = head_q + cnt_lo - ONE_I;
            count_d = count_q - ONE_C;
          end
        end else if (ev_q && (letter_q <= MAX_CODE)) begin
          wr_en  = 1'b1;
          wr_dat = letter_q;
          // Full line scrolls: overwrite the oldest cell and move the left edge.
          if (count_q == DEPTH_C) begin
            wr_addr = head_q;
            head_d  = head_q + ONE_I;
          end else begin
            wr_addr = head_q + cnt_lo;
            count_d = count_q + ONE_C;
          end
        end
      end
    endcase

    full_d = (count_d == DEPTH_C);
    // The drop decision uses the state the event will meet one edge later.
    if (state_d == ST_CLEAR) begin
      drop_d = ev_d | bksp_d;
    end else begin
      drop_d = ev_d & ~clr_d & ~bksp_d & (letter_d > MAX_CODE);
    end

    if ((state_q == ST_IDLE) && ({1'b0, RD_IDX} < count_q)) begin
      rd_letter_d = mem_q[head_q + RD_IDX];
    end else begin
      rd_letter_d = BLANK;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_CLEAR;
      sweep_q     <= '0;
      head_q      <= '0;
      count_q     <= '0;
      strobe_q    <= 1'b1;
      ev_q        <= 1'b0;
      letter_q    <= '0;
      bksp_q      <= 1'b0;
      clr_q       <= 1'b0;
      drop_q      <= 1'b0;
      full_q      <= 1'b0;
      rd_letter_q <= BLANK;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      head_q      <= head_d;
      count_q     <= count_d;
      strobe_q    <= strobe_d;
      ev_q        <= ev_d;
      letter_q    <= letter_d;
      bksp_q      <= bksp_d;
      clr_q       <= clr_d;
      drop_q      <= drop_d;
      full_q      <= full_d;
      rd_letter_q <= rd_letter_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign RD_LETTER = rd_letter_q;
  assign COUNT     = count_q;
  assign FULL      = full_q;
  assign BUSY      = (state_q == ST_CLEAR);
  assign DROP      = drop_q;

endmodule

// File: doc/letter_line_ctrl.md
# letter_line_ctrl

Display-line controller between the letter decoder and the VGA text renderer. Captures each decoded letter on a rising edge of the decoder's strobe, places it in a DEPTH-cell ring buffer, and handles backspace, clear and scroll-on-full. A registered random-access read port lets the VGA pixel pipeline fetch the letter for any on-screen cell. Replaces the strobe-clocked letter register at top level with a fully synchronous, single-clock path.

## Interface
Parameters:
- DEPTH, 16: number of character cells; power of two, 4..64.
- IW, 4: index width, log2(DEPTH).
- BLANK, 5'd31: code returned for empty cells.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- STROBE  in  1  decoder letter-valid level; a 0→1 transition is one letter event.
- LETTER  in  5  decoder letter code; 0..25 = A..Z, 26..31 invalid.
- BKSP  in  1  single-cycle pulse; delete newest letter.
- CLR  in  1  single-cycle pulse; erase the whole line.
- RD_IDX  in  IW  cell index requested by the VGA side; 0 = leftmost.
- RD_LETTER  out  5  letter at RD_IDX, registered.
- COUNT  out  IW+1  letters currently stored, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH.
- BUSY  out  1  clear sweep in progress.
- DROP  out  1  one-cycle pulse: event discarded (busy or invalid code).

## Operation
- Storage: DEPTH×5 register array, head pointer (IW bits, oldest cell) and COUNT. Logical cell i maps to physical (head + i) mod DEPTH; wrap is natural IW-bit overflow.
- Edge detect: strobe_q <= STROBE each cycle. Letter event = STROBE & ~strobe_q, with LETTER sampled in that cycle.
- States: CLEAR, IDLE.
  - CLEAR: sweep counter 0..DEPTH-1 writes BLANK to one physical cell per cycle. Then enter IDLE with head=0, COUNT=0. BUSY=1 throughout.
  - IDLE: one event is processed per cycle, priority CLR > BKSP > letter.
- CLR in IDLE: enter CLEAR next cycle; any BKSP or letter in the same cycle is ignored with no DROP.
- BKSP: if COUNT>0, write BLANK to cell COUNT-1 and decrement COUNT. If COUNT==0, no effect.
- Letter, code 0..25:
  - COUNT<DEPTH: write to cell COUNT and increment COUNT.
  - COUNT==DEPTH (scroll): write to physical cell head and advance head by 1. COUNT stays DEPTH. The oldest letter is lost and the line shifts left by one.
- Letter with code 26..31: not stored; DROP pulses.
- Letter event or BKSP while BUSY: discarded; DROP pulses. CLR while BUSY restarts the sweep at cell 0.
- Read: RD_LETTER <= (RD_IDX < COUNT && !BUSY) ? cell(RD_IDX) : BLANK.
- Reset (async assert, any state): state=CLEAR, sweep=0, head=0, COUNT=0, strobe_q=1, RD_LETTER=BLANK, BUSY=1, DROP=0, FULL=0. With strobe_q=1, a STROBE held high through reset is not an event. Array contents are undefined until the sweep completes.

## Timing
- Reset release: BUSY stays 1 for exactly DEPTH cycles, then 0 with COUNT=0.
- Letter: STROBE rises and is sampled at edge N. The array is written and COUNT/FULL update at edge N+1, both visible after N+1.
- Read latency is 1 cycle: RD_IDX sampled at edge k gives RD_LETTER valid after edge k.
- A read of the cell written at edge N+1 returns the new letter if RD_IDX is sampled at edge N+2 or later.
- DROP is asserted for the single cycle after the discarded event's sampling edge.
- CLR accepted at edge N: BUSY=1 after N+1; BUSY=0 after edge N+1+DEPTH.
- Sustained throughput is one event per cycle. STROBE held high produces exactly one event.

## Test plan
- Reset then idle, DEPTH=16: BUSY=1 for 16 cycles then 0. COUNT=0. RD_LETTER=31 for RD_IDX 0..15.
- Strobe 3, 7, 0 (D, H, A) with STROBE high 5 cycles each: COUNT=3. RD_IDX 0,1,2 return 3,7,0. RD_IDX 3 returns 31.
- Send 17 letters 0..16: after the 17th, FULL=1 and COUNT=16. RD_IDX 0 returns 1, RD_IDX 15 returns 16.
- Store 2 letters, then BKSP ×3: COUNT goes 1, then 0, then stays 0. RD_IDX 0 returns 31.
- BKSP and a letter event in the same cycle with COUNT=4: COUNT becomes 3, the letter is not stored, no DROP. Then CLR with a simultaneous letter: BUSY for 16 cycles, COUNT=0.
- Letter code 27: DROP=1 for one cycle, COUNT unchanged. Letter during BUSY: DROP=1, not stored. Async RESET mid-sweep: outputs return to reset values immediately.
